// File: rtl/dec_arb_pkg.sv
// Shared definitions for dec_share_arbiter: FSM encodings and default sizing.
package dec_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/dec_share_arbiter_rr_pick.sv
// Combinational winner select: round-robin from ptr, or lowest index when
// DEC_FIXED_PRIO_EN is defined.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] win,
    output logic [IW-1:0]    idx
);

`ifdef DEC_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^ptr;

    always_comb begin
        win = '0;
        idx = '0;
        // Descending scan so the lowest set index is the last one written.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                win    = '0;
                win[k] = 1'b1;
                idx    = IW'(k);
            end
        end
    end
`else
    always_comb begin
        int j;
        win = '0;
        idx = '0;
        j   = 0;
        // Scan priority offsets from lowest to highest priority; ptr itself
        // (offset 0) is visited last and therefore wins when requesting.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[j]) begin
                win    = '0;
                win[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end
`endif

endmodule

// File: rtl/dec_share_arbiter.sv
// Arbitrates N_REQ requesters onto one count-down register (IDLE/RUN/DONE).
// Define DEC_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module dec_share_arbiter
    import dec_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_val,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       cnt,
    output logic                   busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0] r_done, w_done_nxt;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [IW-1:0]    r_widx, w_widx_nxt;
    logic             r_busy;
    logic [IW-1:0]    w_ptr;
    logic [N_REQ-1:0] w_pick_win;
    logic [IW-1:0]    w_pick_idx;
    logic             w_rel;

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req (req),
        .ptr (w_ptr),
        .win (w_pick_win),
        .idx (w_pick_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = '0;
        w_done_nxt  = '0;
        w_cnt_nxt   = r_cnt;
        w_widx_nxt  = r_widx;
        w_rel       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = ST_RUN;
                    w_gnt_nxt   = w_pick_win;
                    w_cnt_nxt   = req_val[int'(w_pick_idx)*WIDTH +: WIDTH];
                    w_widx_nxt  = w_pick_idx;
                end
            end
            ST_RUN: begin
                if (!req[r_widx]) begin
                    w_state_nxt = ST_IDLE;
                    w_rel       = 1'b1;
                end else if (r_cnt != '0) begin
                    w_gnt_nxt = r_gnt;
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    // Terminal count: leave RUN rather than wrap below zero.
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = r_gnt;
                    w_rel       = 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_cnt   <= '0;
            r_widx  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
            r_widx  <= w_widx_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef DEC_FIXED_PRIO_EN
    logic w_unused_rel;
    assign w_unused_rel = w_rel;
    assign w_ptr        = '0;
`else
    logic [IW-1:0] r_ptr;

    // The pointer moves past the job's owner whether it completed or aborted.
    always_ff @(posedge clk) begin
        if (reset)
            r_ptr <= '0;
        else if (w_rel)
            r_ptr <= (r_widx == IW'(N_REQ - 1)) ? '0 : r_widx + 1'b1;
    end
    assign w_ptr = r_ptr;
`endif

    assign gnt  = r_gnt;
    assign done = r_done;
    assign cnt  = r_cnt;
    assign busy = r_busy;

endmodule

// File: tb/tb_dec_share_arbiter.sv
// Directed bench for dec_share_arbiter with a job-level reference model.
module tb_dec_share_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_val;
    logic [N-1:0]   gnt, done;
    logic [W-1:0]   cnt;
    logic           busy;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    dec_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_val (req_val),
        .gnt     (gnt),
        .done    (done),
        .cnt     (cnt),
        .busy    (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef DEC_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (r[k]) return k;
`else
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
`endif
        return 0;
    endfunction

    // Job-level model: a grant at edge g with start value V shows cnt = V - e
    // e edges later, and completes on edge g + V + 1.
    int           m_ph  = 0;  // 0 idle, 1 running a job, 2 completion cycle
    int           m_w   = 0;
    int           m_v   = 0;
    int           m_t0  = 0;
    int           m_ptr = 0;
    logic [W-1:0] m_cnt = '0;

    always @(posedge clk) begin : model
        int e;
        cyc++;
        e = cyc - m_t0;
        if (reset) begin
            m_ph = 0; m_ptr = 0; m_cnt = '0;
        end else if (m_ph == 0) begin
            if (req != '0) begin
                m_w  = pick(req, m_ptr);
                m_v  = int'(req_val[m_w*W +: W]);
                m_cnt = W'(m_v);
                m_t0 = cyc;
                m_ph = 1;
            end
        end else if (m_ph == 1) begin
            if (!req[m_w]) begin
                m_ph = 0; m_ptr = (m_w + 1) % N;
            end else if (e == m_v + 1) begin
                m_ph = 2; m_ptr = (m_w + 1) % N;
            end else begin
                m_cnt = W'(m_v - e);
            end
        end else begin
            m_ph = 0;
        end
    end

    always @(negedge clk) begin : compare
        logic [N-1:0] eg, ed;
        if (cyc > 0) begin
            eg = '0; ed = '0;
            if (m_ph == 1) eg[m_w] = 1'b1;
            if (m_ph == 2) ed[m_w] = 1'b1;
            n_checks++;
            if (gnt !== eg || done !== ed || cnt !== m_cnt || busy !== (m_ph != 0)) begin
                n_err++;
                $display("FAIL model cyc%0d: gnt=%b/%b done=%b/%b cnt=%0d/%0d busy=%b/%b (got/expected)",
                         cyc, gnt, eg, done, ed, cnt, m_cnt, busy, (m_ph != 0));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic setv(input int i, input int v);
        req_val[i*W +: W] = W'(v);
    endtask

    task automatic wait_done(input string name, input logic [N-1:0] m);
        int k = 0;
        do begin tick(); k++; end while (done !== m && k < 60);
        if (done !== m) begin
            n_checks++; n_err++;
            $display("FAIL %s: timeout, done=%b required %b", name, done, m);
        end
    endtask

    task automatic wait_any_done(input string name, output int idx);
        int k = 0;
        idx = -1;
        do begin tick(); k++; end while (done == '0 && k < 60);
        for (int i = 0; i < N; i++) if (done[i]) idx = i;
        if (done == '0) begin
            n_checks++; n_err++;
            $display("FAIL %s: timeout, done=%b required nonzero", name, done);
        end
    endtask

    task automatic wait_cnt(input string name, input int v);
        int k = 0;
        do begin tick(); k++; end while (!(gnt != '0 && cnt == W'(v)) && k < 60);
        if (!(gnt != '0 && cnt == W'(v))) begin
            n_checks++; n_err++;
            $display("FAIL %s: timeout, cnt=%0d required %0d", name, cnt, v);
        end
    endtask

    initial begin : stim
        int order[5];
        int t_done[5];
        int idx;
`ifdef DEC_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        reset = 1'b1; req = '0; req_val = '0;
        tick(); tick();
        chk("rst_gnt", gnt, 0); chk("rst_done", done, 0);
        chk("rst_cnt", cnt, 0); chk("rst_busy", busy, 0);
        reset = 1'b0;

        // Single request, V=3: gnt at t+1, cnt 3,2,1,0, done at t+5.
        req = 4'b0001; setv(0, 3);
        tick();
        chk("t1_gnt", gnt, 4'b0001); chk("t1_cnt3", cnt, 3); chk("t1_busy", busy, 1);
        for (int k = 2; k >= 0; k--) begin
            tick();
            chk("t1_cnt", cnt, k); chk("t1_gnt_run", gnt, 4'b0001);
        end
        tick();
        chk("t1_done", done, 4'b0001); chk("t1_gnt_off", gnt, 0); chk("t1_busy_done", busy, 1);
        req = '0;
        tick();
        chk("t1_idle_busy", busy, 0); chk("t1_idle_done", done, 0);

        // Zero start value: one RUN cycle then done.
        req = 4'b0100; setv(2, 0);
        tick();
        chk("t2_gnt", gnt, 4'b0100); chk("t2_cnt", cnt, 0);
        tick();
        chk("t2_done", done, 4'b0100); chk("t2_gnt_off", gnt, 0); chk("t2_cnt_done", cnt, 0);
        req = '0;
        tick();

        // Fairness: all four requesting, value 1 each, from a fresh pointer.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) setv(i, 1);
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_any_done("t3_wait", idx);
            t_done[j] = cyc;
            chk("t3_order", idx, order[j]);
            if (j > 0) chk("t3_spacing", t_done[j] - t_done[j-1], 4);
        end
        req = '0;
        tick();

        // Abort when cnt reaches 7.
        req = 4'b0010; setv(1, 10);
        wait_cnt("t4_wait7", 7);
        req = '0;
        tick();
        chk("t4_gnt", gnt, 0); chk("t4_busy", busy, 0);
        chk("t4_done", done, 0); chk("t4_cnt_hold", cnt, 7);
        req = 4'b0101; setv(0, 0); setv(2, 0);
        tick();
`ifdef DEC_FIXED_PRIO_EN
        chk("t4_next_gnt", gnt, 4'b0001);
`else
        chk("t4_next_gnt", gnt, 4'b0100);
`endif
        req = '0;
        tick();

        // Reset mid-run at cnt=5, then 1001 re-presented.
        req = 4'b0001; setv(0, 8);
        wait_cnt("t5_wait5", 5);
        reset = 1'b1;
        tick();
        chk("t5_gnt", gnt, 0); chk("t5_done", done, 0);
        chk("t5_cnt", cnt, 0); chk("t5_busy", busy, 0);
        reset = 1'b0;
        req = 4'b1001; setv(0, 0); setv(3, 0);
        tick();
        chk("t5_regrant", gnt, 4'b0001);
        req = 4'b0001;
        tick();
        chk("t5_done0", done, 4'b0001);
        req = '0;
        tick();

        // Late request raised during another requester's done cycle.
        req = 4'b0010; setv(1, 2);
        wait_done("t6_wait1", 4'b0010);
        req = 4'b1000; setv(3, 1);
        tick();
        chk("t6_idle_gnt", gnt, 0); chk("t6_idle_busy", busy, 0);
        tick();
        chk("t6_gnt3", gnt, 4'b1000);
        wait_done("t6_wait3", 4'b1000);
        req = '0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
